flash_stream_reader: RTL and testbench
======================================

# flash_stream_reader

Wishbone master that sits directly upstream of the 16-bit flash slave and turns a (start address, word count) command into a sequence of flash reads. For each word it programs the slave's address registers, waits a configurable settle time, reads the data word, and pushes it into a small output FIFO presented as a valid/ready stream. It is intended for boot-image and ROM-shadow copies out of the DE0 parallel flash.

## Interface
- WAIT_CYCLES, 3: idle cycles between the last address write and the data read (flash access time); 0 = no settle.
- FIFO_DEPTH, 4: output FIFO depth in words, power of two, ≥2.
- wb_clk_i  in  1  clock; the only clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready.
- cmd_addr  in  22  start word address.
- cmd_len  in  16  word count; 0 = no-op.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  16  FIFO head word.
- out_last  out  1  head is the command's final word.
- busy  out  1  command accepted and not yet done.
- done  out  1  one-cycle completion pulse.
- wbm_adr_o  out  1  slave register select: 0 = address[15:0], 1 = address[21:16].
- wbm_dat_o  out  16  write data.
- wbm_dat_i  in  16  read data.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  2  byte selects, constant 2'b11.
- wbm_stb_o, wbm_cyc_o  out  1 each  strobe/cycle, always driven equal.
- wbm_ack_i  in  1  slave acknowledge.

## Operation
- States: IDLE, SET_HI, SET_LO, SETTLE, READ, DRAIN.
- IDLE: on accept latch addr, remaining = cmd_len, busy=1. len 0 -> DRAIN with no bus traffic. Else -> SET_HI.
- SET_HI: write, wbm_adr_o=1, wbm_dat_o={10'b0, addr[21:16]}; on ack -> SET_LO.
- SET_LO: write, wbm_adr_o=0, wbm_dat_o=addr[15:0]; on ack -> SETTLE (WAIT_CYCLES>0) else READ.
- SETTLE: count WAIT_CYCLES cycles, stb low -> READ.
- READ: entered/strobed only when FIFO not full (stb held low while full). Read, wbm_we_o=0; on ack push wbm_dat_i with last flag = (remaining==1); remaining-=1; addr+=1 mod 2^22. If remaining now 0 -> DRAIN; else if new addr[15:0]==0 -> SET_HI; else SET_LO.
- DRAIN: wait until FIFO empty, then done=1 for one cycle, busy=0 -> IDLE. For len 0 done pulses the cycle after accept.
- A bus access keeps stb/cyc and all outputs stable until wbm_ack_i; ack sampled on clock edge; stb drops the cycle after ack unless the next state also strobes (back-to-back accesses allowed, each ack consumes one access).
- SET_HI issued for the first word and on every 64K-word boundary crossing only.
- Address wrap 0x3FFFFF -> 0x000000 (hi rewritten as 0).
- FIFO: push and pop in same cycle allowed when full or empty-with-push-not-bypassed (no combinational bypass: pushed word visible next cycle).
- Reset: FSM IDLE, FIFO emptied, counters 0; all outputs 0 except cmd_ready=1 after reset deasserts, wbm_sel_o=2'b11. Reset mid-burst aborts immediately, stb drops in the reset cycle's next edge.
- cmd_valid while busy ignored (cmd_ready=0).

## Timing
- Accept at edge N: SET_HI strobe cycle N+1; with same-cycle ack SET_LO N+2, SETTLE N+3..N+2+W, READ N+3+W, out_valid N+4+W.
- Steady state per word with zero-wait ack: W+2 cycles (SET_LO, SETTLE×W, READ); +1 at 64K crossings.
- done asserted the cycle after the FIFO becomes empty in DRAIN.

## Test plan
- Single word: addr 0x012345, len 1, W=3 -> writes hi 0x0001, lo 0x2345, read at N+6, one output word with out_last=1, done after pop.
- Boundary: addr 0x00FFFE, len 3 -> writes hi 0x0000, lo 0xFFFE, lo 0xFFFF, hi 0x0001, lo 0x0000; three words in order, out_last only on third.
- Backpressure: len 8, out_ready=0 -> exactly 4 reads then stb low; release -> remaining 4 read, order intact, no duplicates.
- len 0 -> no stb ever, done pulse one cycle after accept, cmd_ready back next cycle.
- Slow slave: ack delayed 2 cycles -> stb/adr/dat/we held stable 3 cycles per access, data identical to zero-wait case.
- Reset asserted mid-burst (after 2 of 6 words) -> out_valid=0, busy=0, stb=0 next cycle; new command then runs cleanly from SET_HI.

Source files
------------

// File: rtl/flash_stream_reader_if.sv
// flash_stream_reader_if
//
// Bundles every non-clock signal of flash_stream_reader: the command
// handshake, the output word stream, the status flags and the Wishbone
// master bus toward the 16-bit flash slave.
//
// Modports:
//   master - the reader's view (drives cmd_ready, the stream, status, wbm_*_o)
//   slave  - the environment's view (drives commands, out_ready, wbm_dat_i, wbm_ack_i)
//
// Signals:
//   cmd_valid/cmd_ready  command handshake, accepted when both are high
//   cmd_addr  [21:0]     start word address
//   cmd_len   [15:0]     word count, 0 is a no-op
//   out_valid/out_ready  output stream handshake
//   out_data  [15:0]     head word of the output FIFO
//   out_last             head word is the final word of its command
//   busy                 command accepted and not yet completed
//   done                 one-cycle completion pulse
//   wbm_*                Wishbone master bus (adr 1 = address[21:16], 0 = address[15:0])
interface flash_stream_reader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        wbm_adr_o;
  logic [15:0] wbm_dat_o;
  logic [15:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [1:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, out_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, out_valid, out_data, out_last, busy, done,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, out_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, out_valid, out_data, out_last, busy, done,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );
endinterface

// File: rtl/flash_stream_reader.sv
// flash_stream_reader
//
// Wishbone master that copies a run of words out of the 16-bit parallel
// flash slave. A command (start address, word count) is turned into a
// sequence of address-register writes, a settle delay and a data read per
// word; each word lands in a small FIFO presented as a valid/ready stream.
//
// Parameters:
//   WAIT_CYCLES  idle cycles between the low-address write and the read
//   FIFO_DEPTH   output FIFO depth in words (power of two, at least 2)
//
// Ports:
//   wb_clk_i  clock
//   wb_rst_i  synchronous active-high reset
//   bus       flash_stream_reader_if master modport (command, stream,
//             status and Wishbone bus)
module flash_stream_reader #(
  parameter int WAIT_CYCLES = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  flash_stream_reader_if.master        bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    SET_HI,
    SET_LO,
    SETTLE,
    READ,
    DRAIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [21:0] addr;
  logic [21:0] addr_inc;
  logic [15:0] remaining;
  logic [15:0] wait_cnt;

  logic [16:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic accept;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic access_done;

  logic        stb;
  logic        we;
  logic        adr;
  logic [15:0] dat;
  logic        done;

  assign accept      = bus.cmd_valid && (state == IDLE);
  assign fifo_full   = (count == CW'(FIFO_DEPTH));
  assign fifo_empty  = (count == '0);
  assign pop         = !fifo_empty && bus.out_ready;
  assign access_done = stb && bus.wbm_ack_i;
  assign push        = (state == READ) && access_done;
  assign addr_inc    = addr + 22'd1;

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and bus outputs. Bus outputs are a pure function of the
  // current state and the latched address, so they stay stable for the
  // whole access until ack. A read is only strobed while the FIFO has room,
  // which guarantees every acked read can be pushed.
  always_comb begin
    state_next = state;
    stb        = 1'b0;
    we         = 1'b0;
    adr        = 1'b0;
    dat        = 16'h0000;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (bus.cmd_len == 16'd0) ? DRAIN : SET_HI;
        end
      end
      SET_HI: begin
        stb = 1'b1;
        we  = 1'b1;
        adr = 1'b1;
        dat = {10'b0, addr[21:16]};
        if (access_done) begin
          state_next = SET_LO;
        end
      end
      SET_LO: begin
        stb = 1'b1;
        we  = 1'b1;
        dat = addr[15:0];
        if (access_done) begin
          state_next = (WAIT_CYCLES > 0) ? SETTLE : READ;
        end
      end
      SETTLE: begin
        if (wait_cnt == 16'(WAIT_CYCLES - 1)) begin
          state_next = READ;
        end
      end
      READ: begin
        stb = !fifo_full;
        if (access_done) begin
          if (remaining == 16'd1) begin
            state_next = DRAIN;
          end else if (addr_inc[15:0] == 16'h0000) begin
            state_next = SET_HI;
          end else begin
            state_next = SET_LO;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command datapath: current word address, words still to read and the
  // settle counter. The counter restarts every time the low address
  // register is written, so it always measures time since the last write.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      addr      <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      if (accept) begin
        addr      <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end
      if (state == SET_LO) begin
        wait_cnt <= '0;
      end else if (state == SETTLE) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (push) begin
        remaining <= remaining - 16'd1;
        addr      <= addr_inc;
      end
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because the depth
  // is a power of two.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {last flag, data word}. No reset needed; the head is
  // masked while the FIFO is empty.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {(remaining == 16'd1), bus.wbm_dat_i};
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr][15:0];
  assign bus.out_last  = !fifo_empty && fifo_mem[rd_ptr][16];

  assign bus.wbm_stb_o = stb;
  assign bus.wbm_cyc_o = stb;
  assign bus.wbm_we_o  = we;
  assign bus.wbm_adr_o = adr;
  assign bus.wbm_dat_o = dat;
  assign bus.wbm_sel_o = 2'b11;

endmodule

// File: tb/tb_flash_stream_reader.sv
// tb_flash_stream_reader
//
// Bench for flash_stream_reader (WAIT_CYCLES=3, FIFO_DEPTH=4). A flash
// slave model holds the address registers written by the reader and
// returns a fixed function of the 22-bit address, acknowledging after a
// configurable number of wait cycles. Expected bus writes and output words
// are queued when each command is issued and consumed as the reader
// produces them.
module tb_flash_stream_reader;

  localparam int W     = 3;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  flash_stream_reader_if bus ();

  flash_stream_reader #(
    .WAIT_CYCLES(W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  int cycle_count = 0;

  // Slave model state.
  int         ack_delay = 0;
  int         slave_wait = 0;
  logic [5:0]  reg_hi = '0;
  logic [15:0] reg_lo = '0;

  // Scoreboards: {adr, data} for writes, {last, data} for output words.
  logic [16:0] exp_writes [$];
  logic [16:0] exp_out [$];

  // Per-command observations.
  int hi_writes, lo_writes, read_count, pop_count, done_count;
  int first_hi, first_read, first_valid, done_cyc, last_pop_cyc, accept_cyc;
  logic        in_access = 1'b0;
  logic [17:0] held;
  int          access_len;

  typedef struct {
    logic [21:0] addr;
    int          len;
    int          delay;
    int          exp_hi;
    int          exp_lo;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [15:0] flash_word(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], 4'hC, a[21:16]} ^ 16'h03A5;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Slave acknowledges once the strobe has been held for ack_delay cycles.
  assign bus.wbm_ack_i = bus.wbm_stb_o && (slave_wait >= ack_delay);
  assign bus.wbm_dat_i = flash_word({reg_hi, reg_lo});

  always @(posedge clk) begin
    if (bus.wbm_stb_o && bus.wbm_ack_i) begin
      slave_wait <= 0;
      if (bus.wbm_we_o) begin
        if (bus.wbm_adr_o) reg_hi <= bus.wbm_dat_o[5:0];
        else               reg_lo <= bus.wbm_dat_o;
      end
    end else if (bus.wbm_stb_o) begin
      slave_wait <= slave_wait + 1;
    end else begin
      slave_wait <= 0;
    end
  end

  // Bus and stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wbm_stb_o) begin
      if (in_access) begin
        checkOutput("bus_hold", {14'b0, bus.wbm_adr_o, bus.wbm_we_o, bus.wbm_dat_o}, {14'b0, held});
        access_len++;
      end else begin
        held       = {bus.wbm_adr_o, bus.wbm_we_o, bus.wbm_dat_o};
        access_len = 1;
        in_access  = 1'b1;
        if (bus.wbm_we_o && bus.wbm_adr_o && first_hi < 0) first_hi = cycle_count;
        if (!bus.wbm_we_o && first_read < 0) first_read = cycle_count;
      end
      if (bus.wbm_ack_i) begin
        checkOutput("ack_latency", access_len, ack_delay + 1);
        in_access = 1'b0;
        if (bus.wbm_we_o) begin
          if (bus.wbm_adr_o) hi_writes++;
          else               lo_writes++;
          checkOutput("write_expected", exp_writes.size() != 0, 1);
          if (exp_writes.size() != 0) begin
            checkOutput("bus_write", {15'b0, bus.wbm_adr_o, bus.wbm_dat_o}, {15'b0, exp_writes.pop_front()});
          end
        end else begin
          read_count++;
        end
      end
    end else if (in_access) begin
      checkOutput("stb_dropped_before_ack", 0, 1);
      in_access = 1'b0;
    end
    if (rst) in_access = 1'b0;

    if (bus.out_valid && first_valid < 0) first_valid = cycle_count;
    if (bus.out_valid && bus.out_ready) begin
      pop_count++;
      last_pop_cyc = cycle_count;
      checkOutput("out_expected", exp_out.size() != 0, 1);
      if (exp_out.size() != 0) begin
        checkOutput("out_word", {15'b0, bus.out_last, bus.out_data}, {15'b0, exp_out.pop_front()});
      end
    end
    if (bus.done) begin
      done_count++;
      done_cyc = cycle_count;
    end
  end

  // Queues the expected bus writes and output words for a command, then
  // presents the command for one accept edge.
  task automatic applyStimulus(input logic [21:0] start, input int len, input int delay);
    logic [21:0] a;
    @(posedge clk); #1;
    ack_delay   = delay;
    hi_writes   = 0;  lo_writes  = 0;  read_count  = 0;
    pop_count   = 0;  done_count = 0;
    first_hi    = -1; first_read = -1; first_valid = -1;
    done_cyc    = -1; last_pop_cyc = -1;
    for (int i = 0; i < len; i++) begin
      a = start + 22'(i);
      if (i == 0 || a[15:0] == 16'h0000) exp_writes.push_back({1'b1, 10'b0, a[21:16]});
      exp_writes.push_back({1'b0, a[15:0]});
      exp_out.push_back({(i == len - 1), flash_word(a)});
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = start;
    bus.cmd_len   = 16'(len);
    @(posedge clk); #1;
    accept_cyc    = cycle_count;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (done_count == 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_seen", done_count > 0, 1);
    checkOutput("ready_after_done", bus.cmd_ready, 1);
    checkOutput("busy_after_done", bus.busy, 0);
    checkOutput("done_single_pulse", bus.done, 0);
  endtask

  task automatic checkCounts(input int exp_hi, input int exp_lo, input int len);
    checkOutput("hi_writes", hi_writes, exp_hi);
    checkOutput("lo_writes", lo_writes, exp_lo);
    checkOutput("read_count", read_count, len);
    checkOutput("pop_count", pop_count, len);
    checkOutput("out_queue_left", exp_out.size(), 0);
    checkOutput("write_queue_left", exp_writes.size(), 0);
    checkOutput("done_count", done_count, 1);
  endtask

  initial begin
    vecs[0] = '{addr: 22'h012345, len: 1,  delay: 0, exp_hi: 1, exp_lo: 1};
    vecs[1] = '{addr: 22'h00FFFE, len: 3,  delay: 0, exp_hi: 2, exp_lo: 3};
    vecs[2] = '{addr: 22'h3FFFFF, len: 2,  delay: 1, exp_hi: 2, exp_lo: 2};
    vecs[3] = '{addr: 22'h000010, len: 6,  delay: 2, exp_hi: 1, exp_lo: 6};
    vecs[4] = '{addr: 22'h2ABCDE, len: 0,  delay: 0, exp_hi: 0, exp_lo: 0};
    vecs[5] = '{addr: 22'h1FFFF0, len: 20, delay: 0, exp_hi: 2, exp_lo: 20};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] reset state");
    checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_stb_cyc", {bus.wbm_stb_o, bus.wbm_cyc_o}, 0);
    checkOutput("reset_sel", bus.wbm_sel_o, 2'b11);
    checkOutput("reset_bus_out", {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o}, 0);

    $display("[TB] single word timing");
    applyStimulus(22'h012345, 1, 0);
    waitDone(100);
    checkOutput("set_hi_cycle", first_hi - accept_cyc, 0);
    checkOutput("read_cycle", first_read - accept_cyc, 5);
    checkOutput("out_valid_cycle", first_valid - accept_cyc, 6);
    checkOutput("done_after_empty", done_cyc - last_pop_cyc, 1);
    checkCounts(1, 1, 1);

    $display("[TB] command table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].len, vecs[i].delay);
      waitDone(600);
      if (vecs[i].len == 0) begin
        checkOutput("len0_done_cycle", done_cyc - accept_cyc, 0);
        checkOutput("len0_no_strobe", first_hi + first_read, -2);
      end else begin
        checkOutput("done_after_empty", done_cyc - last_pop_cyc, 1);
      end
      checkCounts(vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].len);
    end

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(22'h054320, 8, 0);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("bp_reads_while_full", read_count, DEPTH);
    checkOutput("bp_stb_low", bus.wbm_stb_o, 0);
    checkOutput("bp_out_valid", bus.out_valid, 1);
    checkOutput("bp_busy", bus.busy, 1);
    bus.out_ready = 1'b1;
    waitDone(300);
    checkCounts(1, 8, 8);

    $display("[TB] reset mid-burst");
    bus.out_ready = 1'b0;
    applyStimulus(22'h0ABCD0, 6, 0);
    for (int n = 0; n < 200 && read_count < 2; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("reads_before_reset", read_count >= 2, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_stb", bus.wbm_stb_o, 0);
    rst = 1'b0;
    exp_out.delete();
    exp_writes.delete();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    applyStimulus(22'h00FFFF, 2, 0);
    waitDone(200);
    checkOutput("restart_set_hi", first_hi - accept_cyc, 0);
    checkCounts(2, 2, 2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
